// File: rtl/mc_controller.sv
// Control FSM for the 16-bit multicycle RISC datapath: sequences fetch,
// decode, execute and writeback, and drives every datapath select and strobe.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic [1:0] cz_field,
  input  logic       compare,
  output logic [2:0] Mux1_alu_B,
  output logic [2:0] Mux2_alu_A,
  output logic [1:0] Mux3_RF_wen,
  output logic [2:0] Mux4_RF_wadd,
  output logic [1:0] Mux5_RF_read2,
  output logic       Mux6_RF_dataIn,
  output logic [1:0] Mux8_memwrite,
  output logic       Mux9_memDataIn,
  output logic       ALU_op,
  output logic       CZen,
  output logic       memRead,
  output logic       wIR,
  output logic       wtmpA,
  output logic [2:0] counter
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(7);

  // Opcodes (IR[15:12])
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_ADI = 4'b0001;
  localparam logic [3:0] OP_NDU = 4'b0010;
  localparam logic [3:0] OP_LHI = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SW  = 4'b0101;
  localparam logic [3:0] OP_LM  = 4'b0110;
  localparam logic [3:0] OP_SM  = 4'b0111;
  localparam logic [3:0] OP_JAL = 4'b1000;
  localparam logic [3:0] OP_JLR = 4'b1001;
  localparam logic [3:0] OP_BEQ = 4'b1100;

  // ALU B operand select
  localparam logic [2:0] B_ZERO = 3'd0;
  localparam logic [2:0] B_RB   = 3'd2;
  localparam logic [2:0] B_IMM6 = 3'd3;
  localparam logic [2:0] B_CNT  = 3'd4;
  // ALU A operand select
  localparam logic [2:0] A_ZERO = 3'd0;
  localparam logic [2:0] A_ONE  = 3'd1;
  localparam logic [2:0] A_SHL7 = 3'd2;
  localparam logic [2:0] A_IMM6 = 3'd3;
  localparam logic [2:0] A_IMM9 = 3'd4;
  localparam logic [2:0] A_RA   = 3'd5;
  localparam logic [2:0] A_TMPA = 3'd6;
  // Register-file write enable source
  localparam logic [1:0] WEN_ON  = 2'd1;
  localparam logic [1:0] WEN_CZ  = 2'd2;
  localparam logic [1:0] WEN_BIT = 2'd3;
  // Register-file write address select
  localparam logic [2:0] WA_IR119 = 3'd0;
  localparam logic [2:0] WA_IR53  = 3'd1;
  localparam logic [2:0] WA_CNT   = 3'd2;
  localparam logic [2:0] WA_R7    = 3'd3;
  localparam logic [2:0] WA_IR86  = 3'd4;
  // Register-file second read port select
  localparam logic [1:0] RD_IR86 = 2'd0;
  localparam logic [1:0] RD_CNT  = 2'd1;
  localparam logic [1:0] RD_R7   = 2'd2;
  // Register-file write data select
  localparam logic DIN_MEM = 1'b0;
  localparam logic DIN_T1  = 1'b1;
  // Memory write strobe source
  localparam logic [1:0] MW_ON  = 2'd1;
  localparam logic [1:0] MW_BIT = 2'd2;
  // Memory write data select
  localparam logic MD_A = 1'b0;
  localparam logic MD_B = 1'b1;

  // ADD and NDU get their own execute states, and the register-type
  // writeback is split by cz_field, so every output stays a pure state decode.
  typedef enum logic [4:0] {
    S_RESET, S_IF0, S_IF1, S_IF2, S_DEC,
    S_EX_ADD, S_EX_NDU, S_WB_RU, S_WB_RC,
    S_EX_I, S_WB_I, S_EX_H, S_WB_H,
    S_EA, S_MEM_LW, S_MEM_SW,
    S_EX_B, S_BR1, S_BR2,
    S_J1, S_J2_AL, S_J2_LR, S_J3,
    S_LM_A, S_LM_M, S_SM_A, S_SM_M
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;

  assign counter = counter_q;

  // State and LM/SM counter registers; reset drops to RESET immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RESET;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Next-state, counter update and Moore output decode
  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    Mux1_alu_B     = B_ZERO;
    Mux2_alu_A     = A_ZERO;
    Mux3_RF_wen    = 2'd0;
    Mux4_RF_wadd   = WA_IR119;
    Mux5_RF_read2  = RD_IR86;
    Mux6_RF_dataIn = DIN_MEM;
    Mux8_memwrite  = 2'd0;
    Mux9_memDataIn = MD_A;
    ALU_op         = 1'b0;
    CZen           = 1'b0;
    memRead        = 1'b0;
    wIR            = 1'b0;
    wtmpA          = 1'b0;

    case (state_q)
      S_RESET: state_d = S_IF0;
      S_IF0: begin
        Mux5_RF_read2 = RD_R7;
        Mux1_alu_B    = B_RB;
        state_d       = S_IF1;
      end
      S_IF1: begin
        memRead       = 1'b1;
        wIR           = 1'b1;
        Mux2_alu_A    = A_ONE;
        Mux1_alu_B    = B_RB;
        Mux5_RF_read2 = RD_R7;
        state_d       = S_IF2;
      end
      S_IF2: begin
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_R7;
        Mux6_RF_dataIn = DIN_T1;
        state_d        = S_DEC;
      end
      S_DEC: begin
        wtmpA     = 1'b1;
        counter_d = '0;
        case (opcode)
          OP_ADD:  state_d = S_EX_ADD;
          OP_NDU:  state_d = S_EX_NDU;
          OP_ADI:  state_d = S_EX_I;
          OP_LHI:  state_d = S_EX_H;
          OP_LW:   state_d = S_EA;
          OP_SW:   state_d = S_EA;
          OP_BEQ:  state_d = S_EX_B;
          OP_JAL:  state_d = S_J1;
          OP_JLR:  state_d = S_J1;
          OP_LM:   state_d = S_LM_A;
          OP_SM:   state_d = S_SM_A;
          default: state_d = S_IF0;
        endcase
      end
      S_EX_ADD, S_EX_NDU: begin
        Mux2_alu_A    = A_RA;
        Mux1_alu_B    = B_RB;
        Mux5_RF_read2 = RD_IR86;
        ALU_op        = (state_q == S_EX_NDU);
        CZen          = 1'b1;
        state_d       = (cz_field == 2'b00) ? S_WB_RU : S_WB_RC;
      end
      S_WB_RU, S_WB_RC: begin
        Mux3_RF_wen    = (state_q == S_WB_RU) ? WEN_ON : WEN_CZ;
        Mux4_RF_wadd   = WA_IR53;
        Mux6_RF_dataIn = DIN_T1;
        state_d        = S_IF0;
      end
      S_EX_I: begin
        Mux2_alu_A = A_RA;
        Mux1_alu_B = B_IMM6;
        CZen       = 1'b1;
        state_d    = S_WB_I;
      end
      S_WB_I: begin
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_IR86;
        Mux6_RF_dataIn = DIN_T1;
        state_d        = S_IF0;
      end
      S_EX_H: begin
        Mux2_alu_A = A_SHL7;
        Mux1_alu_B = B_ZERO;
        state_d    = S_WB_H;
      end
      S_WB_H: begin
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_IR119;
        Mux6_RF_dataIn = DIN_T1;
        state_d        = S_IF0;
      end
      S_EA: begin
        Mux2_alu_A    = A_IMM6;
        Mux1_alu_B    = B_RB;
        Mux5_RF_read2 = RD_IR86;
        state_d       = (opcode == OP_SW) ? S_MEM_SW : S_MEM_LW;
      end
      S_MEM_LW: begin
        memRead        = 1'b1;
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_IR119;
        Mux6_RF_dataIn = DIN_MEM;
        state_d        = S_IF0;
      end
      S_MEM_SW: begin
        Mux8_memwrite  = MW_ON;
        Mux9_memDataIn = MD_A;
        state_d        = S_IF0;
      end
      S_EX_B: begin
        Mux2_alu_A    = A_RA;
        Mux1_alu_B    = B_RB;
        Mux5_RF_read2 = RD_IR86;
        state_d       = compare ? S_BR1 : S_IF0;
      end
      // R7 already holds PC+1 here, so the target is PC+1+imm6
      S_BR1: begin
        Mux2_alu_A    = A_IMM6;
        Mux1_alu_B    = B_RB;
        Mux5_RF_read2 = RD_R7;
        state_d       = S_BR2;
      end
      S_BR2: begin
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_R7;
        Mux6_RF_dataIn = DIN_T1;
        state_d        = S_IF0;
      end
      S_J1: begin
        Mux2_alu_A    = A_ZERO;
        Mux1_alu_B    = B_RB;
        Mux5_RF_read2 = RD_R7;
        state_d       = (opcode == OP_JAL) ? S_J2_AL : S_J2_LR;
      end
      S_J2_AL, S_J2_LR: begin
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_IR119;
        Mux6_RF_dataIn = DIN_T1;
        Mux1_alu_B     = B_RB;
        Mux2_alu_A     = (state_q == S_J2_AL) ? A_IMM9 : A_ZERO;
        Mux5_RF_read2  = (state_q == S_J2_AL) ? RD_R7 : RD_IR86;
        state_d        = S_J3;
      end
      S_J3: begin
        Mux3_RF_wen    = WEN_ON;
        Mux4_RF_wadd   = WA_R7;
        Mux6_RF_dataIn = DIN_T1;
        state_d        = S_IF0;
      end
      S_LM_A, S_SM_A: begin
        Mux2_alu_A = A_TMPA;
        Mux1_alu_B = B_CNT;
        state_d    = (state_q == S_LM_A) ? S_LM_M : S_SM_M;
      end
      // Every register slot is visited; the IR mask only gates the strobe
      S_LM_M: begin
        memRead        = 1'b1;
        Mux3_RF_wen    = WEN_BIT;
        Mux4_RF_wadd   = WA_CNT;
        Mux6_RF_dataIn = DIN_MEM;
        if (counter_q == CNT_LAST) begin
          state_d = S_IF0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
          state_d   = S_LM_A;
        end
      end
      S_SM_M: begin
        Mux8_memwrite  = MW_BIT;
        Mux5_RF_read2  = RD_CNT;
        Mux9_memDataIn = MD_B;
        if (counter_q == CNT_LAST) begin
          state_d = S_IF0;
        end else begin
          counter_d = counter_q + CNT_W'(1);
          state_d   = S_SM_A;
        end
      end
      default: state_d = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: stimulus queues the expected output
// vector for each upcoming cycle; a monitor pops and compares each sample.
module tb_mc_controller;

  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] m2;
    logic [1:0] m3;
    logic [2:0] m4;
    logic [1:0] m5;
    logic       m6;
    logic [1:0] m8;
    logic       m9;
    logic       alu;
    logic       czen;
    logic       mrd;
    logic       wir;
    logic       wtmp;
    logic [2:0] cnt;
  } outs_t;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [1:0] cz_field;
  logic       compare;
  logic [2:0] Mux1_alu_B;
  logic [2:0] Mux2_alu_A;
  logic [1:0] Mux3_RF_wen;
  logic [2:0] Mux4_RF_wadd;
  logic [1:0] Mux5_RF_read2;
  logic       Mux6_RF_dataIn;
  logic [1:0] Mux8_memwrite;
  logic       Mux9_memDataIn;
  logic       ALU_op;
  logic       CZen;
  logic       memRead;
  logic       wIR;
  logic       wtmpA;
  logic [2:0] counter;

  outs_t exp_q[$];
  string nm_q[$];
  event  chk_now;
  int    n_checks = 0;
  int    n_fail   = 0;

  mc_controller dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .cz_field       (cz_field),
    .compare        (compare),
    .Mux1_alu_B     (Mux1_alu_B),
    .Mux2_alu_A     (Mux2_alu_A),
    .Mux3_RF_wen    (Mux3_RF_wen),
    .Mux4_RF_wadd   (Mux4_RF_wadd),
    .Mux5_RF_read2  (Mux5_RF_read2),
    .Mux6_RF_dataIn (Mux6_RF_dataIn),
    .Mux8_memwrite  (Mux8_memwrite),
    .Mux9_memDataIn (Mux9_memDataIn),
    .ALU_op         (ALU_op),
    .CZen           (CZen),
    .memRead        (memRead),
    .wIR            (wIR),
    .wtmpA          (wtmpA),
    .counter        (counter)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Build an expected vector, argument order matches outs_t
  function automatic outs_t ev(int m1, int m2, int m3, int m4, int m5, int m6, int m8,
                               int m9, int alu, int czen, int mrd, int wir, int wtmp,
                               int cnt);
    outs_t v;
    v.m1   = 3'(m1);
    v.m2   = 3'(m2);
    v.m3   = 2'(m3);
    v.m4   = 3'(m4);
    v.m5   = 2'(m5);
    v.m6   = 1'(m6);
    v.m8   = 2'(m8);
    v.m9   = 1'(m9);
    v.alu  = 1'(alu);
    v.czen = 1'(czen);
    v.mrd  = 1'(mrd);
    v.wir  = 1'(wir);
    v.wtmp = 1'(wtmp);
    v.cnt  = 3'(cnt);
    return v;
  endfunction

  function automatic string fmt(outs_t v);
    return $sformatf("m1=%0d m2=%0d m3=%0d m4=%0d m5=%0d m6=%0d m8=%0d m9=%0d alu=%0d cz=%0d mr=%0d wir=%0d wtmp=%0d cnt=%0d",
                     v.m1, v.m2, v.m3, v.m4, v.m5, v.m6, v.m8, v.m9, v.alu, v.czen,
                     v.mrd, v.wir, v.wtmp, v.cnt);
  endfunction

  // Monitor: one scoreboard entry per falling edge, or on demand
  initial begin : monitor
    outs_t act;
    outs_t exp;
    string nm;
    forever begin
      @(negedge clk or chk_now);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nm  = nm_q.pop_front();
        act = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
               Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, ALU_op, CZen, memRead,
               wIR, wtmpA, counter};
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL %s: got {%s} expected {%s}", nm, fmt(act), fmt(exp));
        end
      end
    end
  end

  task automatic push(input string nm, input outs_t v);
    exp_q.push_back(v);
    nm_q.push_back(nm);
  endtask

  // Wait until the monitor has consumed every queued expectation
  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      #1;
      guard++;
      if (guard > 100) begin
        $display("FAIL drain: scoreboard stuck with %0d entries", exp_q.size());
        $fatal(1, "scoreboard drain bound expired");
      end
    end
  endtask

  // Inputs change just after the edge that enters IF0
  task automatic start(input logic [3:0] op, input logic [1:0] cz, input logic cmp);
    @(posedge clk);
    #1;
    opcode   = op;
    cz_field = cz;
    compare  = cmp;
  endtask

  task automatic fetch(input int c);
    push("IF0", ev(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, c));
    push("IF1", ev(2, 1, 0, 0, 2, 0, 0, 0, 0, 0, 1, 1, 0, c));
    push("IF2", ev(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, c));
    push("DEC", ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, c));
  endtask

  initial begin : stimulus
    outs_t z;
    z        = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset    = 1'b1;
    opcode   = 4'b0000;
    cz_field = 2'b00;
    compare  = 1'b0;
    #1 reset = 1'b0;
    repeat (3) push("reset_hold", z);
    drain();
    reset = 1'b1;

    // ADD, unconditional write
    start(4'b0000, 2'b00, 1'b0);
    fetch(0);
    push("add_ex", ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push("add_wb", ev(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // ADD, conditional write via CZout
    start(4'b0000, 2'b10, 1'b0);
    fetch(0);
    push("addc_ex", ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push("addc_wb", ev(0, 0, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // NDU
    start(4'b0010, 2'b00, 1'b0);
    fetch(0);
    push("ndu_ex", ev(2, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    push("ndu_wb", ev(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // ADI
    start(4'b0001, 2'b00, 1'b0);
    fetch(0);
    push("adi_ex", ev(3, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push("adi_wb", ev(0, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // LHI
    start(4'b0011, 2'b00, 1'b0);
    fetch(0);
    push("lhi_ex", ev(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("lhi_wb", ev(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // LW
    start(4'b0100, 2'b00, 1'b0);
    fetch(0);
    push("lw_ea",  ev(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("lw_mem", ev(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    drain();

    // SW
    start(4'b0101, 2'b00, 1'b0);
    fetch(0);
    push("sw_ea",  ev(2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("sw_mem", ev(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // BEQ taken
    start(4'b1100, 2'b00, 1'b1);
    fetch(0);
    push("beq_ex",  ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("beq_br1", ev(2, 3, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("beq_br2", ev(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // BEQ not taken: straight back to IF0
    start(4'b1100, 2'b00, 1'b0);
    fetch(0);
    push("beqn_ex", ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // JAL
    start(4'b1000, 2'b00, 1'b0);
    fetch(0);
    push("jal_j1", ev(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("jal_j2", ev(2, 4, 1, 0, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    push("jal_j3", ev(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // JLR
    start(4'b1001, 2'b00, 1'b0);
    fetch(0);
    push("jlr_j1", ev(2, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    push("jlr_j2", ev(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    push("jlr_j3", ev(0, 0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    // LM: eight address/memory pairs, counter 0..7
    start(4'b0110, 2'b00, 1'b0);
    fetch(0);
    for (int k = 0; k < 8; k++) begin
      push($sformatf("lm_a%0d", k), ev(4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k));
      push($sformatf("lm_m%0d", k), ev(0, 0, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, k));
    end
    drain();

    // Undefined opcode: counter still 7 until DEC clears it
    start(4'b1111, 2'b00, 1'b0);
    fetch(7);
    drain();

    // SM, interrupted by reset in SM_M with counter=3
    start(4'b0111, 2'b00, 1'b0);
    fetch(0);
    for (int k = 0; k < 4; k++) begin
      push($sformatf("sm_a%0d", k), ev(4, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, k));
      push($sformatf("sm_m%0d", k), ev(0, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0, 0, 0, k));
    end
    drain();
    reset = 1'b0;
    #1;
    push("rst_async", z);
    ->chk_now;
    #1;
    repeat (2) push("rst_mid_hold", z);
    drain();
    reset = 1'b1;

    // Clean restart after the interrupted SM
    start(4'b0000, 2'b00, 1'b0);
    fetch(0);
    push("add2_ex", ev(2, 5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    push("add2_wb", ev(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control FSM for the 16-bit multicycle RISC datapath.
- Sits directly upstream of the datapath and drives every mux select, write enable, ALU op and the LM/SM counter each cycle.
- Decodes IR[15:12] and steps fetch/decode/execute/writeback sequences; reads back the ALU compare flag.
- R7 is the PC.

Parameters:
- none (encodings below are fixed)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 forces RESET state immediately
- opcode  in  4  IR[15:12]
- cz_field  in  2  IR[1:0] (00 = unconditional write)
- compare  in  1  ALU equality flag (A==B), combinational from datapath
- Mux1_alu_B  out  3  0:0, 1:1, 2:B, 3:imm6, 4:counter
- Mux2_alu_A  out  3  0:0, 1:1, 2:shift7, 3:imm6, 4:imm9, 5:A, 6:tmpA
- Mux3_RF_wen  out  2  0:off, 1:on, 2:CZout, 3:IR bit select
- Mux4_RF_wadd  out  3  0:IR[11:9], 1:IR[5:3], 2:counter, 3:R7, 4:IR[8:6]
- Mux5_RF_read2  out  2  0:IR[8:6], 1:counter, 2:R7
- Mux6_RF_dataIn  out  1  0:memDataOut, 1:T1
- Mux8_memwrite  out  2  0:off, 1:on, 2:IR bit select
- Mux9_memDataIn  out  1  0:A, 1:B
- ALU_op  out  1  0:add, 1:nand
- CZen  out  1  update C/Z flags
- memRead  out  1  memory read strobe
- wIR  out  1  IR load
- wtmpA  out  1  tmpA load
- counter  out  3  LM/SM register index, registered

Behaviour:
- Outputs are Moore, decoded from state only. Every output not listed for a state is 0, including in RESET. counter resets to 0.
- T1 latches ALU_out every cycle, so a value computed in state S is available as T1 in S+1.
- Fetch sequence:
  - RESET → IF0 on first clk after reset deasserts.
  - IF0: read2=R7, A=0, B=B → T1=PC.
  - IF1: memRead=1, wIR=1; A=1, B=B, read2=R7 → T1=PC+1.
  - IF2: wen=1, wadd=R7, dataIn=T1. Next state DEC.
  - DEC: wtmpA=1; counter←0; dispatch on opcode.
- ADD-class (0000, ADD) and NDU (0010):
  - EX_R: A=A, B=B, read2=IR[8:6], ALU_op=0 or 1, CZen=1.
  - WB_R: wadd=IR[5:3], dataIn=T1, wen = 1 if cz_field==00 else CZout (sel 2).
  - → IF0. Total 6 cycles.
- ADI (0001):
  - EX_I: A=A, B=imm6, CZen=1.
  - WB_I: wen=1, wadd=IR[8:6], dataIn=T1.
- LHI (0011):
  - EX_H: A=shift7, B=0.
  - WB_H: wen=1, wadd=IR[11:9], dataIn=T1.
- LW (0100):
  - EA: A=imm6, B=B, read2=IR[8:6].
  - MEM_LW: memRead=1, wen=1, wadd=IR[11:9], dataIn=mem.
- SW (0101):
  - EA as for LW.
  - MEM_SW: memwrite=1, Mux9=A.
- BEQ (1100):
  - EX_B: A=A, B=B, read2=IR[8:6].
  - compare=0 → IF0.
  - compare=1 → BR1: A=imm6, B=B, read2=R7 (target = PC+1+imm6) → BR2: wen=1, wadd=R7, dataIn=T1 → IF0.
- JAL (1000):
  - J1: A=0, B=B, read2=R7.
  - J2: write IR[11:9]←T1; A=imm9, B=B, read2=R7.
  - J3: write R7←T1.
- JLR (1001): same as JAL except J2 uses A=0, read2=IR[8:6].
- LM (0110), strict block: address = tmpA + counter.
  - LM_A: A=tmpA, B=counter.
  - LM_M: memRead=1, wen sel 3, wadd=counter, dataIn=mem.
  - On LM_M exit: counter==7 → IF0; else counter+1 → LM_A.
  - Bit select: counter k uses IR[7-k].
- SM (0111):
  - SM_A: as LM_A.
  - SM_M: memwrite sel 2, read2=counter, Mux9=B.
  - Loop rule same as LM. LM/SM always take 16 cycles of loop regardless of mask.
- counter: 3-bit. Changes only in DEC (clear) and LM_M/SM_M (increment); never wraps into a new loop.
- Undefined opcodes (1010, 1011, 1101, 1110, 1111): DEC → IF0; no side effects.
- Reset mid-instruction: all strobes drop combinationally on assertion; no partial write completes after reset.

Test Plan:
- Reset low 3 cycles, then high → RESET, IF0, IF1, IF2, DEC. wIR=1 only in IF1; every output 0 while reset=0.
- ADD, cz_field=00 → 6-cycle sequence; WB_R drives Mux3=1, Mux4=1, Mux6=1. With cz_field=10 → Mux3=2 in WB_R.
- BEQ with compare=1 → EX_B, BR1 (Mux2=3, Mux5=2), BR2 (Mux4=3), then IF0. With compare=0 → IF0 directly after EX_B.
- LM → counter steps 0..7 across 8 LM_A/LM_M pairs, Mux3=3 in each LM_M, returns to IF0 after counter=7, and counter is cleared at next DEC.
- SM, then reset asserted during SM_M with counter=3 → Mux8=0 immediately, counter=0, and restart at IF0.
- opcode=1111 → DEC→IF0; no wen, memwrite or CZen asserted anywhere in the instruction.
